// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide unit state encoding.
// Holds the OP opcode, the M-extension func_7 tag, the eight M func_3 codes,
// the iteration count and the ex_muldiv FSM state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // One shift/accumulate step per clock edge, one step per operand bit.
  localparam int MD_STEPS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit sitting in the EX stage.
// Ports: i_clk/i_rst (async active-high); i_valid, i_opcode, i_func_3, i_func_7,
//   i_rs_1, i_rs_2, i_rd_num from ID/EX; result/rd_num/done (one-cycle pulse), busy, stall out.
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_func_3,
  input  logic [6:0]      i_func_7,
  input  logic [XLEN-1:0] i_rs_1,
  input  logic [XLEN-1:0] i_rs_2,
  input  logic [4:0]      i_rd_num,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_num,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam logic [5:0]      LAST_CNT = 6'(MD_STEPS - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  // ---------------------------------------------------------------------------
  // Accept decode and operand preparation (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            in_is_div;
  logic            rs1_signed, rs2_signed;
  logic            sgn_1, sgn_2;
  logic [XLEN-1:0] mag_1, mag_2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign accept = (state_q == MD_IDLE) && i_valid &&
                  (i_opcode == OPCODE_OP) && (i_func_7 == FUNC7_MULDIV);

  assign in_is_div  = i_func_3[2];
  // MUL only keeps the low half, which is identical for signed and unsigned
  // operands, so it is run as unsigned.
  assign rs1_signed = (i_func_3 == F3_MULH) || (i_func_3 == F3_MULHSU) ||
                      (i_func_3 == F3_DIV)  || (i_func_3 == F3_REM);
  assign rs2_signed = (i_func_3 == F3_MULH) || (i_func_3 == F3_DIV) ||
                      (i_func_3 == F3_REM);

  assign sgn_1 = rs1_signed & i_rs_1[XLEN-1];
  assign sgn_2 = rs2_signed & i_rs_2[XLEN-1];
  // INT_MIN negates to itself, which is its correct unsigned magnitude.
  assign mag_1 = sgn_1 ? (~i_rs_1 + 1'b1) : i_rs_1;
  assign mag_2 = sgn_2 ? (~i_rs_2 + 1'b1) : i_rs_2;

  assign div_zero = (i_rs_2 == '0);
  assign div_ovf  = ((i_func_3 == F3_DIV) || (i_func_3 == F3_REM)) &&
                    (i_rs_1 == INT_MIN) && (i_rs_2 == '1);
  assign special  = in_is_div && (div_zero || div_ovf);

  // func_3[1] separates remainder ops (REM/REMU) from quotient ops (DIV/DIVU).
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = i_func_3[1] ? i_rs_1 : '1;
    end else begin
      special_res = i_func_3[1] ? '0 : INT_MIN;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared 64-bit shift/accumulate step
  //   multiply: acc = {partial high, multiplier}, add-then-shift-right
  //   divide  : acc = {remainder, dividend/quotient}, shift-left-then-subtract
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_hi;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, div_rem;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] step;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // The shifted partial remainder needs XLEN+1 bits when the divisor exceeds
  // 2^(XLEN-1); the true difference always fits XLEN bits when div_ge is set.
  assign div_hi   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_hi >= {1'b0, opa_q};
  assign div_diff = div_hi[XLEN-1:0] - opa_q;
  assign div_rem  = div_ge ? div_diff : div_hi[XLEN-1:0];
  assign div_step = {div_rem, acc_q[XLEN-2:0], div_ge};

  assign step = f3_q[2] ? div_step : mul_step;

  // ---------------------------------------------------------------------------
  // Sign correction of the final step
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   final_res;

  assign prod_fix = neg_q ? (~step + 1'b1) : step;
  assign div_sel  = f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];

  always_comb begin
    final_res = '0;
    if (f3_q[2]) begin
      final_res = neg_q ? (~div_sel + 1'b1) : div_sel;
    end else if (f3_q == F3_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (accept) begin
      f3_d  = i_func_3;
      rd_d  = i_rd_num;
      cnt_d = '0;
      acc_d = {{XLEN{1'b0}}, (in_is_div ? mag_1 : mag_2)};
      opa_d = in_is_div ? mag_2 : mag_1;
      // Remainder takes the dividend's sign; everything else the product of signs.
      neg_d = (i_func_3 == F3_REM) ? sgn_1 : (sgn_1 ^ sgn_2);
      if (special) begin
        result_d = special_res;
      end
    end else if (state_q == MD_BUSY) begin
      acc_d = step;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LAST_CNT) begin
        result_d = final_res;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          state_d = special ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == MD_BUSY);
    done  = (state_q == MD_DONE);
    // While reset is held nothing is accepted, so no freeze is requested.
    stall = ~i_rst & ((state_q == MD_BUSY) | accept);
  end

  assign result = result_q;
  assign rd_num = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import riscv_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic [6:0]  i_func_7;
  logic [31:0] i_rs_1;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic [31:0] result;
  logic [4:0]  rd_num;
  logic        done;
  logic        busy;
  logic        stall;

  int n_chk = 0;
  int n_bad = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_opcode (i_opcode),
    .i_func_3 (i_func_3),
    .i_func_7 (i_func_7),
    .i_rs_1   (i_rs_1),
    .i_rs_2   (i_rs_2),
    .i_rd_num (i_rd_num),
    .result   (result),
    .rd_num   (rd_num),
    .done     (done),
    .busy     (busy),
    .stall    (stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    i_valid  = 1'b1;
    i_opcode = OPCODE_OP;
    i_func_7 = FUNC7_MULDIV;
    i_func_3 = f3;
    i_rs_1   = a;
    i_rs_2   = b;
    i_rd_num = rd;
  endtask

  // Issue one M op, follow it to done, check latency, busy length, result,
  // rd, the single-cycle done pulse and that the result is held afterwards.
  // With poke set, a different valid M op is presented while busy.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_edges, input bit poke);
    int n;
    int nb;
    @(negedge i_clk);
    drive_m(f3, a, b, rd);
    #1 chk({tag, "/stall_at_accept"}, 64'(stall), 64'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid  = 1'b0;
    i_rs_1   = 32'h5A5A5A5A;
    i_rs_2   = 32'h12345678;
    i_rd_num = 5'd31;
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      nb += int'(busy);
      if (poke && n == 3)  drive_m(F3_MUL, 32'h1, 32'h1, 5'd30);
      if (poke && n == 20) i_valid = 1'b0;
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b0;
    chk({tag, "/edges_to_done"}, 64'(n), 64'(exp_edges));
    chk({tag, "/busy_cycles"}, 64'(nb), 64'(exp_edges));
    chk({tag, "/result"}, 64'(result), 64'(exp_res));
    chk({tag, "/rd_num"}, 64'(rd_num), 64'(rd));
    @(negedge i_clk);
    chk({tag, "/done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "/result_held"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int seen;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_opcode = 7'd0;
    i_func_3 = 3'd0;
    i_func_7 = 7'd0;
    i_rs_1   = 32'd0;
    i_rs_2   = 32'd0;
    i_rd_num = 5'd0;
    #1;
    chk("reset/result", 64'(result), 64'd0);
    chk("reset/rd_num", 64'(rd_num), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/stall", 64'(stall), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Multiplies
    run_op("mul_7_m3",     F3_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 32, 1'b1);
    run_op("mulh_min_min", F3_MULH,   32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 32, 1'b0);
    run_op("mulhu_max",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 32, 1'b0);
    run_op("mulhsu_m1_2",  F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd4, 32'hFFFFFFFF, 32, 1'b0);
    run_op("mulhu_min_3",  F3_MULHU,  32'h80000000, 32'h00000003, 5'd5, 32'h00000001, 32, 1'b0);

    // Special-case divides complete straight from IDLE
    run_op("div_ovf",      F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 0, 1'b0);
    run_op("rem_ovf",      F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd7, 32'h00000000, 0, 1'b0);
    run_op("divu_by0",     F3_DIVU,   32'h00000005, 32'h00000000, 5'd8, 32'hFFFFFFFF, 0, 1'b0);
    run_op("remu_by0",     F3_REMU,   32'h00000005, 32'h00000000, 5'd9, 32'h00000005, 0, 1'b0);

    // Iterative divides
    run_op("rem_m7_2",     F3_REM,    32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF, 32, 1'b0);
    run_op("div_m7_2",     F3_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFD, 32, 1'b0);
    run_op("divu_100_7",   F3_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       32, 1'b0);
    run_op("remu_big",     F3_REMU,   32'hFFFFFFFF, 32'h80000001, 5'd13, 32'h7FFFFFFE, 32, 1'b0);

    // Non-M instructions are not accepted
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_opcode = OPCODE_OP;
    i_func_7 = 7'b0000000;
    i_func_3 = F3_MUL;
    #1 chk("nonm_f7/stall", 64'(stall), 64'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      seen += int'(busy) + int'(done);
    end
    chk("nonm_f7/no_activity", 64'(seen), 64'd0);
    i_opcode = 7'b0010011;
    i_func_7 = FUNC7_MULDIV;
    #1 chk("nonm_opc/stall", 64'(stall), 64'd0);
    @(negedge i_clk);
    chk("nonm_opc/busy", 64'(busy), 64'd0);
    i_valid = 1'b0;

    // Reset in the middle of a DIV
    @(negedge i_clk);
    drive_m(F3_DIV, 32'd100, 32'd7, 5'd20);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid/result", 64'(result), 64'd0);
    chk("rst_mid/rd_num", 64'(rd_num), 64'd0);
    chk("rst_mid/busy", 64'(busy), 64'd0);
    chk("rst_mid/done", 64'(done), 64'd0);
    chk("rst_mid/stall", 64'(stall), 64'd0);
    drive_m(F3_MUL, 32'd3, 32'd4, 5'd21);
    #1 chk("rst_held/stall", 64'(stall), 64'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst   = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      seen += int'(done);
    end
    chk("rst_mid/no_done", 64'(seen), 64'd0);
    run_op("mul_3_4", F3_MUL, 32'd3, 32'd4, 5'd22, 32'd12, 32, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
